// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// - DEF_WIDTH   : default operand/result width.
// - ST_*        : FSM state encodings.
// - ovf_ref()   : signed two's-complement overflow from operand and result MSBs.
package serial_addsub_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Add overflows when both operands share a sign the result lacks; subtract overflows
  // when the operand signs differ and the result sign differs from the minuend.
  function automatic logic ovf_ref(input logic a_msb, input logic b_msb, input logic y_msb,
                                   input logic sub);
    logic same_sign;
    same_sign = (a_msb == b_msb);
    if (sub) begin
      return !same_sign && (y_msb != a_msb);
    end
    return same_sign && (y_msb != a_msb);
  endfunction

endpackage

// File: rtl/fa_fs_bit.sv
// Combinational 1-bit full adder / full subtractor cell.
// Ports:
//   x, y  : operand bits (x - y when subtracting)
//   cin   : incoming carry (add) or borrow (sub)
//   sub   : 0 = add, 1 = subtract
//   s     : sum / difference bit
//   cout  : outgoing carry (add) or borrow (sub)
module fa_fs_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  logic x_eff;
  logic p;

  // Borrow generate is ~x&y; inverting x lets one carry equation serve both modes.
  assign x_eff = x ^ sub;
  assign p     = x_eff ^ y;
  assign s     = x ^ y ^ cin;
  assign cout  = (x_eff & y) | (cin & p);

endmodule

// File: rtl/serial_addsub16.sv
// Bit-serial adder/subtractor: computes a+b or a-b one bit per clock, LSB first,
// using a single full-adder/subtractor cell.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request, sampled only when busy=0
//   sub      : 0 = add, 1 = subtract (captured with start)
//   a, b     : operands (captured with start)
//   y        : registered result
//   cout     : final carry (add) or borrow (sub)
//   ovf      : signed overflow
//   busy     : high while computing
//   done     : one-cycle completion pulse; y/cout/ovf valid
module serial_addsub16
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Only WIDTH-1 result bits need storing; the last bit goes straight to y.
  logic [WIDTH-2:0] y_sh_q;
  logic             c_q;
  logic             sub_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] y_full;
  logic             last_bit;

  fa_fs_bit u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (c_q),
    .sub  (sub_q),
    .s    (s_bit),
    .cout (c_next)
  );

  assign y_full   = {s_bit, y_sh_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      y_sh_q  <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          y_sh_q <= y_full[WIDTH-1:1];
          c_q    <= c_next;
          cnt_q  <= cnt_q + 1'b1;
          if (last_bit) begin
            // Operand LSBs are the original MSBs at this point.
            y_q     <= y_full;
            cout_q  <= c_next;
            ovf_q   <= ovf_ref(a_sh_q[0], b_sh_q[0], s_bit, sub_q);
            state_q <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE gives back-to-back issue.
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            sub_q   <= sub;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_addsub16.sv
module tb_serial_addsub16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  exp_t sb_q[$];

  serial_addsub16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .y     (y),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub);
    exp_t e;
    logic [W:0] r;
    int sa, sb, sr;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      r  = {1'b0, ma} - {1'b0, mb};
      sr = sa - sb;
    end else begin
      r  = {1'b0, ma} + {1'b0, mb};
      sr = sa + sb;
    end
    e.y    = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  // Drive one request at a negedge; result is expected WIDTH+1 cycles after the sampling edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input exp_t e);
    exp_t q;
    wait_ready();
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    q     = e;
    q.cyc = cyc + W + 1;
    sb_q.push_back(q);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    sub   = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
  endtask

  // Output monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        exp_t e;
        if (prev_done === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
        end
        chk("done_not_busy", busy, 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 with y=%h, required no done", y);
        end else begin
          e = sb_q.pop_front();
          chk("y", y, e.y);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          chk("latency_cycle", cyc, e.cyc);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    exp_t e;
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, y: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 16'h0003, b: 16'h0005, sub: 1'b1, y: 16'hFFFE, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, y: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, y: 16'h7FFF, cout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, sub: 1'b0, y: 16'h0000, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 16'h1234, b: 16'h0001, sub: 1'b0, y: 16'h1235, cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 16'h8000, b: 16'h8000, sub: 1'b0, y: 16'h0000, cout: 1'b1, ovf: 1'b1};
    vecs[7] = '{a: 16'h0005, b: 16'h0005, sub: 1'b1, y: 16'h0000, cout: 1'b0, ovf: 1'b0};
    vecs[8] = '{a: 16'h0000, b: 16'h0001, sub: 1'b1, y: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
    vecs[9] = '{a: 16'h00FF, b: 16'h0F0F, sub: 1'b0, y: 16'h100E, cout: 1'b0, ovf: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_y", y, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Table vectors issued back-to-back (each start lands in the previous DONE cycle)
    for (int i = 0; i < 10; i++) begin
      e.y    = vecs[i].y;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      e.cyc  = 0;
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, e);
    end
    drain();
    chk("idle_holds_y", y, 16'h100E);

    // Start pulsed mid-RUN with other operands must be ignored
    issue(16'h0102, 16'h0304, 1'b0, model(16'h0102, 16'h0304, 1'b0));
    repeat (3) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    a     = 16'h5555;
    b     = 16'hAAAA;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("after_ignored_y", y, 16'h0406);

    // Reset mid-RUN discards the operation without a done pulse
    a     = 16'h1234;
    b     = 16'h0001;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_y", y, 0);
    chk("rst_mid_cout", cout, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_done", done, 0);
    repeat (25) @(negedge clk);
    issue(16'h1234, 16'h0001, 1'b0, model(16'h1234, 16'h0001, 1'b0));
    drain();

    // Simultaneous rst and start: rst wins
    a     = 16'h0001;
    b     = 16'h0001;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_start_busy", busy, 0);
    repeat (20) @(negedge clk);

    // Random traffic against the golden model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = $urandom();
      rb = $urandom();
      rs = $urandom_range(0, 1);
      issue(ra, rb, rs, model(ra, rb, rs));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
